// File: rtl/paddle_pkg.sv
// Shared types and geometry helpers for the multi-player paddle controller.
package paddle_pkg;

  // Per-player auto-repeat state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Decoded key request / latched movement direction.
  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  // Leftmost legal paddle position.
  function automatic int calc_min_x(input int side);
    return side;
  endfunction

  // Rightmost legal paddle position (left edge of the paddle).
  function automatic int calc_max_x(input int screen_w, input int side, input int paddle_w);
    return screen_w - side - paddle_w;
  endfunction

  // Tick counter width; never narrower than one bit.
  function automatic int calc_cnt_w(input int repeat_delay, input int repeat_rate);
    int m;
    m = (repeat_delay > repeat_rate) ? repeat_delay : repeat_rate;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// Single-player paddle: key decode, press/auto-repeat FSM and edge-aware step unit.
module paddle_axis
  import paddle_pkg::*;
#(
  parameter int X_W          = 10,
  parameter int SCREEN_W     = 800,
  parameter int SIDE         = 40,
  parameter int PADDLE_W     = 75,
  parameter int STEP         = 20,
  parameter int RESET_X      = 349,
  parameter int WRAP_MODE    = 1,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           en,
  input  logic           key_r,
  input  logic           key_l,
  output logic [X_W-1:0] x,
  output logic           moved
);

  localparam int MIN_X = calc_min_x(SIDE);
  localparam int MAX_X = calc_max_x(SCREEN_W, SIDE, PADDLE_W);
  localparam int CNT_W = calc_cnt_w(REPEAT_DELAY, REPEAT_RATE);

  // Geometry in X_W+1 bits so the step arithmetic cannot wrap.
  localparam logic [X_W:0]     MIN_XE     = (X_W+1)'(MIN_X);
  localparam logic [X_W:0]     MAX_XE     = (X_W+1)'(MAX_X);
  localparam logic [X_W:0]     STEP_E     = (X_W+1)'(STEP);
  localparam logic [X_W-1:0]   RESET_XV   = X_W'(RESET_X);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  // One step in direction d from cur, honouring wrap or clamp at the borders.
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] cur, input dir_t d);
    logic [X_W:0] cur_e;
    logic [X_W:0] nxt_e;
    logic [X_W:0] diff_e;
    cur_e  = {1'b0, cur};
    nxt_e  = cur_e;
    diff_e = cur_e - STEP_E;
    case (d)
      DIR_RIGHT: begin
        if (cur_e == MAX_XE) begin
          nxt_e = (WRAP_MODE != 0) ? MIN_XE : cur_e;
        end else begin
          nxt_e = cur_e + STEP_E;
          if (nxt_e > MAX_XE) nxt_e = MAX_XE;
        end
      end
      DIR_LEFT: begin
        if (cur_e == MIN_XE) begin
          nxt_e = (WRAP_MODE != 0) ? MAX_XE : cur_e;
        end else if ((cur_e < STEP_E) || (diff_e < MIN_XE)) begin
          nxt_e = MIN_XE;
        end else begin
          nxt_e = diff_e;
        end
      end
      default: nxt_e = cur_e;
    endcase
    return X_W'(nxt_e);
  endfunction

  dir_t             req;
  dir_t             dir_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_last;
  logic [X_W-1:0]   x_reg;
  logic             moved_reg;
  logic [X_W-1:0]   press_x;
  logic [X_W-1:0]   repeat_x;

  // Decode the key pair; both or neither pressed means no request.
  always_comb begin
    req = DIR_NONE;
    if (key_r && !key_l) begin
      req = DIR_RIGHT;
    end else if (key_l && !key_r) begin
      req = DIR_LEFT;
    end
  end

  assign press_x  = step_x(x_reg, req);
  assign repeat_x = step_x(x_reg, dir_reg);
  assign cnt_last = (state_reg == ST_DELAY) ? DELAY_LAST : RATE_LAST;

  // Press/auto-repeat FSM with registered position and move pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= RESET_XV;
      moved_reg <= 1'b0;
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dir_reg   <= DIR_NONE;
    end else begin
      moved_reg <= 1'b0;
      if (!en) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
        dir_reg   <= DIR_NONE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (req != DIR_NONE) begin
              x_reg     <= press_x;
              moved_reg <= (press_x != x_reg);
              dir_reg   <= req;
              cnt_reg   <= '0;
              state_reg <= ST_DELAY;
            end
          end
          ST_DELAY, ST_REPEAT: begin
            if (req == DIR_NONE) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
              dir_reg   <= DIR_NONE;
            end else if (req != dir_reg) begin
              // Reversal behaves like a fresh press in the new direction.
              x_reg     <= press_x;
              moved_reg <= (press_x != x_reg);
              dir_reg   <= req;
              cnt_reg   <= '0;
              state_reg <= ST_DELAY;
            end else if (tick) begin
              if (cnt_reg == cnt_last) begin
                x_reg     <= repeat_x;
                moved_reg <= (repeat_x != x_reg);
                cnt_reg   <= '0;
                state_reg <= ST_REPEAT;
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            dir_reg   <= DIR_NONE;
          end
        endcase
      end
    end
  end

  assign x     = x_reg;
  assign moved = moved_reg;

endmodule

// File: rtl/paddle_ctrl_multi.sv
// N-player horizontal paddle controller: one paddle_axis per player on packed buses.
module paddle_ctrl_multi
  import paddle_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int X_W          = 10,
  parameter int SCREEN_W     = 800,
  parameter int SIDE         = 40,
  parameter int PADDLE_W     = 75,
  parameter int STEP         = 20,
  parameter int RESET_X      = 349,
  parameter int WRAP_MODE    = 1,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       en,
  input  logic [NUM_PLAYERS-1:0]     key_r,
  input  logic [NUM_PLAYERS-1:0]     key_l,
  output logic [NUM_PLAYERS*X_W-1:0] x,
  output logic [NUM_PLAYERS-1:0]     moved
);

  localparam int MIN_X = calc_min_x(SIDE);
  localparam int MAX_X = calc_max_x(SCREEN_W, SIDE, PADDLE_W);

  // Reject geometry that would let a paddle leave the legal range.
  generate
    if (!((MIN_X < RESET_X) && (RESET_X <= MAX_X) && (MAX_X < (1 << X_W)) && (STEP > 0) &&
          (NUM_PLAYERS >= 1) && (NUM_PLAYERS <= 8) &&
          (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1))) begin : g_param_check
      $fatal(1, "paddle_ctrl_multi: invalid parameter set");
    end
  endgenerate

  // One independent paddle per player.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      paddle_axis #(
        .X_W          (X_W),
        .SCREEN_W     (SCREEN_W),
        .SIDE         (SIDE),
        .PADDLE_W     (PADDLE_W),
        .STEP         (STEP),
        .RESET_X      (RESET_X),
        .WRAP_MODE    (WRAP_MODE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .en    (en),
        .key_r (key_r[gi]),
        .key_l (key_l[gi]),
        .x     (x[gi*X_W +: X_W]),
        .moved (moved[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Bench for paddle_ctrl_multi: a wrap build and a clamp build share one stimulus stream.
module tb_paddle_ctrl_multi;

  localparam int NP      = 2;
  localparam int X_W     = 10;
  localparam int MIN_X   = 40;
  localparam int MAX_X   = 685;
  localparam int STEP    = 20;
  localparam int RESET_X = 349;
  localparam int DLY     = 25;
  localparam int RATE    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              tick = 1'b0;
  logic              en = 1'b0;
  logic [NP-1:0]     key_r = '0;
  logic [NP-1:0]     key_l = '0;
  logic [NP*X_W-1:0] x_w;
  logic [NP*X_W-1:0] x_c;
  logic [NP-1:0]     moved_w;
  logic [NP-1:0]     moved_c;

  always #5 clk = ~clk;

  paddle_ctrl_multi #(.NUM_PLAYERS(NP), .WRAP_MODE(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
    .key_r(key_r), .key_l(key_l), .x(x_w), .moved(moved_w)
  );

  paddle_ctrl_multi #(.NUM_PLAYERS(NP), .WRAP_MODE(0)) dut_clamp (
    .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
    .key_r(key_r), .key_l(key_l), .x(x_c), .moved(moved_c)
  );

  typedef struct {
    logic [NP*X_W-1:0] xw;
    logic [NP*X_W-1:0] xc;
    logic [NP-1:0]     mw;
    logic [NP-1:0]     mc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state per build (0 = wrap, 1 = clamp) and player.
  int            mx[2][NP];
  int            mheld[2][NP];
  int            mticks[2][NP];
  logic [NP-1:0] mmv[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int step_ref(input int xv, input int d, input bit wrap);
    if (d == 2) begin
      if (xv == MAX_X) return wrap ? MIN_X : xv;
      return (xv + STEP > MAX_X) ? MAX_X : xv + STEP;
    end
    if (d == 1) begin
      if (xv == MIN_X) return wrap ? MAX_X : xv;
      return (xv - STEP < MIN_X) ? MIN_X : xv - STEP;
    end
    return xv;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      mmv[w] = '0;
      for (int p = 0; p < NP; p++) begin
        mx[w][p]     = RESET_X;
        mheld[w][p]  = 0;
        mticks[w][p] = 0;
      end
    end
  endtask

  // Reference: a step fires on press, on the DLY-th held tick, then every RATE ticks.
  task automatic model_edge();
    int  req;
    int  nx;
    int  fdir;
    bit  fire;
    for (int w = 0; w < 2; w++) begin
      for (int p = 0; p < NP; p++) begin
        req  = (key_r[p] && !key_l[p]) ? 2 : ((key_l[p] && !key_r[p]) ? 1 : 0);
        fire = 1'b0;
        fdir = 0;
        if (!en || req == 0) begin
          mheld[w][p]  = 0;
          mticks[w][p] = 0;
        end else if (req != mheld[w][p]) begin
          fire = 1'b1;
          fdir = req;
          mheld[w][p]  = req;
          mticks[w][p] = 0;
        end else if (tick) begin
          mticks[w][p]++;
          if (mticks[w][p] == DLY || (mticks[w][p] > DLY && (mticks[w][p] - DLY) % RATE == 0)) begin
            fire = 1'b1;
            fdir = req;
          end
        end
        nx = fire ? step_ref(mx[w][p], fdir, (w == 0)) : mx[w][p];
        mmv[w][p] = (nx != mx[w][p]);
        mx[w][p]  = nx;
      end
    end
  endtask

  function automatic logic [NP*X_W-1:0] pack_x(input int w);
    logic [NP*X_W-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*X_W +: X_W] = X_W'(mx[w][p]);
    return v;
  endfunction

  // One clock: predict, push, let the edge happen, pop and compare every output.
  task automatic cycle();
    exp_t e;
    model_edge();
    e.xw = pack_x(0);
    e.xc = pack_x(1);
    e.mw = mmv[0];
    e.mc = mmv[1];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int p = 0; p < NP; p++) begin
      check($sformatf("x_wrap[%0d]", p),  64'(x_w[p*X_W +: X_W]), 64'(e.xw[p*X_W +: X_W]));
      check($sformatf("x_clamp[%0d]", p), 64'(x_c[p*X_W +: X_W]), 64'(e.xc[p*X_W +: X_W]));
      check($sformatf("moved_wrap[%0d]", p),  64'(moved_w[p]), 64'(e.mw[p]));
      check($sformatf("moved_clamp[%0d]", p), 64'(moved_c[p]), 64'(e.mc[p]));
    end
  endtask

  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      tick = 1'b0;
      repeat (3) cycle();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
    end
  endtask

  task automatic expect_x(input string tag, input int inst, input int p, input int val);
    logic [X_W-1:0] obs;
    obs = (inst == 0) ? x_w[p*X_W +: X_W] : x_c[p*X_W +: X_W];
    check(tag, 64'(obs), 64'(val));
  endtask

  task automatic expect_mv(input string tag, input int inst, input int p, input int val);
    logic obs;
    obs = (inst == 0) ? moved_w[p] : moved_c[p];
    check(tag, 64'(obs), 64'(val));
  endtask

  task automatic pulse_r(input int p);
    key_r[p] = 1'b1; cycle();
    key_r[p] = 1'b0; cycle();
  endtask

  task automatic pulse_l(input int p);
    key_l[p] = 1'b1; cycle();
    key_l[p] = 1'b0; cycle();
  endtask

  initial begin
    // Reset and idle
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      expect_x("reset_x_wrap", 0, p, RESET_X);
      expect_x("reset_x_clamp", 1, p, RESET_X);
      expect_mv("reset_moved", 0, p, 0);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    run_ticks(25);
    expect_x("idle_x0", 0, 0, 349);
    expect_x("idle_x1", 0, 1, 349);

    // Single press on player 0
    key_r[0] = 1'b1; cycle();
    expect_x("pulse_x0", 0, 0, 369);
    expect_mv("pulse_moved0", 0, 0, 1);
    expect_x("pulse_x1", 0, 1, 349);
    key_r[0] = 1'b0; cycle();
    expect_mv("pulse_moved0_once", 0, 0, 0);

    // Back to 349, then hold right through delay and repeats
    pulse_l(0);
    expect_x("back_x0", 0, 0, 349);
    key_r[0] = 1'b1; cycle();
    expect_x("hold_press", 0, 0, 369);
    run_ticks(24);
    expect_x("hold_t24", 0, 0, 369);
    run_ticks(1);
    expect_x("hold_t25", 0, 0, 389);
    run_ticks(5);
    expect_x("hold_t30", 0, 0, 409);
    run_ticks(5);
    expect_x("hold_t35", 0, 0, 429);

    // Reverse mid-repeat: immediate step, delay restarts
    key_r[0] = 1'b0;
    key_l[0] = 1'b1; cycle();
    expect_x("rev_x0", 0, 0, 409);
    expect_mv("rev_moved0", 0, 0, 1);
    run_ticks(24);
    expect_x("rev_t24", 0, 0, 409);
    run_ticks(1);
    expect_x("rev_t25", 0, 0, 389);
    key_l[0] = 1'b0; cycle();

    // Both keys held: no motion
    key_r[0] = 1'b1;
    key_l[0] = 1'b1;
    run_ticks(10);
    expect_x("both_x0", 0, 0, 389);
    expect_mv("both_moved0", 0, 0, 0);

    // Paused with key held, then resume
    key_l[0] = 1'b0;
    en = 1'b0;
    run_ticks(10);
    expect_x("pause_x0", 0, 0, 389);
    expect_mv("pause_moved0", 0, 0, 0);
    en = 1'b1; cycle();
    expect_x("resume_x0", 0, 0, 409);
    key_r[0] = 1'b0; cycle();

    // Right border: wrap versus clamp
    for (int i = 0; i < 13; i++) pulse_r(0);
    expect_x("edge_w669", 0, 0, 669);
    expect_x("edge_c669", 1, 0, 669);
    key_r[0] = 1'b1; cycle();
    expect_x("edge_w685", 0, 0, 685);
    expect_x("edge_c685", 1, 0, 685);
    key_r[0] = 1'b0; cycle();
    key_r[0] = 1'b1; cycle();
    expect_x("wrap_right", 0, 0, 40);
    expect_mv("wrap_right_moved", 0, 0, 1);
    expect_x("clamp_right", 1, 0, 685);
    expect_mv("clamp_right_moved", 1, 0, 0);
    key_r[0] = 1'b0; cycle();
    pulse_l(0);
    expect_x("wrap_left_p0", 0, 0, 685);

    // Left border on player 1
    for (int i = 0; i < 16; i++) pulse_l(1);
    expect_x("left_w40", 0, 1, 40);
    expect_x("left_c40", 1, 1, 40);
    key_l[1] = 1'b1; cycle();
    expect_x("wrap_left_p1", 0, 1, 685);
    expect_x("clamp_left_p1", 1, 1, 40);
    expect_mv("clamp_left_moved", 1, 1, 0);
    key_l[1] = 1'b0; cycle();

    // Asynchronous reset mid-delay, key still held afterwards
    key_r[0] = 1'b1; cycle();
    run_ticks(5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int p = 0; p < NP; p++) begin
      expect_x("async_rst_w", 0, p, RESET_X);
      expect_x("async_rst_c", 1, p, RESET_X);
      expect_mv("async_rst_mv", 0, p, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    expect_x("post_rst_w", 0, 0, 369);
    expect_x("post_rst_c", 1, 0, 369);
    run_ticks(24);
    expect_x("post_rst_t24", 0, 0, 369);
    run_ticks(1);
    expect_x("post_rst_t25", 0, 0, 389);
    key_r[0] = 1'b0; cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
